// File: rtl/uart_rx_cfg.sv
// UART receiver: 2-flop rx synchroniser, mid-bit oversampling, glitch-rejecting
// start detect, optional parity, 1/2 stop bits, LSB/MSB-first data order.
// Ports: clk, rst (async, active-high), rx (serial in), s_tick (oversample en),
//        dout (last word), rx_done (1-clk pulse), parity_err, frame_err, break_det.
module uart_rx_cfg #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1,
  parameter int LSB_FIRST  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  input  logic                 s_tick,
  output logic [DATA_BITS-1:0] dout,
  output logic                 rx_done,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 break_det
);

  localparam int SW = $clog2(OVERSAMPLE);
  localparam int NW = $clog2(DATA_BITS + 1);
  localparam logic [SW-1:0] S_MID = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] S_END = SW'(OVERSAMPLE - 1);
  localparam logic [NW-1:0] N_LAST = NW'(DATA_BITS - 1);
  localparam logic [NW-1:0] N_STOP = NW'(STOP_BITS - 1);
  localparam bit PEN = (PARITY_EN != 0);
  localparam bit ODD = (PARITY_ODD != 0);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BRK_WAIT
  } state_t;

  state_t               r_state;
  logic                 r_sync1;
  logic                 r_sync2;
  logic [SW-1:0]        r_s;
  logic [NW-1:0]        r_n;
  logic [DATA_BITS-1:0] r_sh;
  logic                 r_par_bit;
  logic                 r_stop_bad;
  logic [DATA_BITS-1:0] r_dout;
  logic                 r_rx_done;
  logic                 r_par_err;
  logic                 r_frame_err;
  logic                 r_break;

  state_t               w_state_nx;
  logic [SW-1:0]        w_s_nx;
  logic [NW-1:0]        w_n_nx;
  logic [DATA_BITS-1:0] w_sh_nx;
  logic                 w_par_nx;
  logic                 w_stop_nx;
  logic                 w_done;
  logic                 w_rx_s;
  logic [DATA_BITS-1:0] w_shift;
  logic                 w_stop_fin;
  logic                 w_par_bad;
  logic                 w_brk;

  assign w_rx_s = r_sync2;

  // New bit enters at the end that ends up holding the first-received bit
  // in dout[0] (LSB-first) or dout[DATA_BITS-1] (MSB-first).
  assign w_shift = (LSB_FIRST != 0) ?
    {w_rx_s, r_sh[DATA_BITS-1:1]} :
    {r_sh[DATA_BITS-2:0], w_rx_s};

  // Stop status including the sample being taken on the completing tick.
  assign w_stop_fin = r_stop_bad | ~w_rx_s;
  assign w_par_bad  = PEN && (((^r_sh) ^ r_par_bit) != ODD);
  assign w_brk      = w_stop_fin && (r_sh == '0) &&
                      (!PEN || !r_par_bit);

  always_comb begin
    w_state_nx = r_state;
    w_s_nx     = r_s;
    w_n_nx     = r_n;
    w_sh_nx    = r_sh;
    w_par_nx   = r_par_bit;
    w_stop_nx  = r_stop_bad;
    w_done     = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (!w_rx_s) begin
          w_state_nx = START;
          w_s_nx     = '0;
        end
      end
      START: begin
        if (s_tick) begin
          if (r_s == S_MID) begin
            if (!w_rx_s) begin
              w_state_nx = DATA;
              w_s_nx     = '0;
              w_n_nx     = '0;
              w_par_nx   = 1'b0;
              w_stop_nx  = 1'b0;
            end else begin
              w_state_nx = IDLE;
            end
          end else begin
            w_s_nx = r_s + 1'b1;
          end
        end
      end
      DATA: begin
        if (s_tick) begin
          if (r_s == S_END) begin
            w_sh_nx = w_shift;
            w_s_nx  = '0;
            if (r_n == N_LAST) begin
              w_n_nx     = '0;
              w_state_nx = PEN ? PARITY : STOP;
            end else begin
              w_n_nx = r_n + 1'b1;
            end
          end else begin
            w_s_nx = r_s + 1'b1;
          end
        end
      end
      PARITY: begin
        if (s_tick) begin
          if (r_s == S_END) begin
            w_par_nx   = w_rx_s;
            w_s_nx     = '0;
            w_state_nx = STOP;
          end else begin
            w_s_nx = r_s + 1'b1;
          end
        end
      end
      STOP: begin
        if (s_tick) begin
          if (r_s == S_END) begin
            w_s_nx    = '0;
            w_stop_nx = w_stop_fin;
            if (r_n == N_STOP) begin
              // Leaving at mid-stop lets an abutting start bit be caught.
              w_done     = 1'b1;
              w_n_nx     = '0;
              w_state_nx = w_brk ? BRK_WAIT : IDLE;
            end else begin
              w_n_nx = r_n + 1'b1;
            end
          end else begin
            w_s_nx = r_s + 1'b1;
          end
        end
      end
      BRK_WAIT: begin
        if (w_rx_s) begin
          w_state_nx = IDLE;
        end
      end
      default: begin
        w_state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1     <= 1'b1;
      r_sync2     <= 1'b1;
      r_state     <= IDLE;
      r_s         <= '0;
      r_n         <= '0;
      r_sh        <= '0;
      r_par_bit   <= 1'b0;
      r_stop_bad  <= 1'b0;
      r_dout      <= '0;
      r_rx_done   <= 1'b0;
      r_par_err   <= 1'b0;
      r_frame_err <= 1'b0;
      r_break     <= 1'b0;
    end else begin
      r_sync1    <= rx;
      r_sync2    <= r_sync1;
      r_state    <= w_state_nx;
      r_s        <= w_s_nx;
      r_n        <= w_n_nx;
      r_sh       <= w_sh_nx;
      r_par_bit  <= w_par_nx;
      r_stop_bad <= w_stop_nx;
      r_rx_done  <= w_done;
      if (w_done) begin
        r_dout      <= r_sh;
        r_par_err   <= w_par_bad;
        r_frame_err <= w_stop_fin;
        r_break     <= w_brk;
      end
    end
  end

  assign dout       = r_dout;
  assign rx_done    = r_rx_done;
  assign parity_err = r_par_err;
  assign frame_err  = r_frame_err;
  assign break_det  = r_break;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Testbench for uart_rx_cfg: four configurations (8N1, 8E1, 8N2, 7-bit MSB-first)
// driven by directed frames; expected words queued at send, checked at rx_done.
module tb_uart_rx_cfg;

  localparam int BIT = 64;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       s_tick = 1'b0;
  logic [3:0] rx = 4'hF;
  int         tcnt = 0;

  logic [7:0] d0, d1, d2;
  logic [6:0] d3;
  logic [3:0] done, pe, fe, bk;
  logic [3:0] done_q = 4'h0;

  int checks = 0;
  int failures = 0;

  typedef struct {
    int         k;
    logic [7:0] d;
    logic       pe;
    logic       fe;
    logic       bk;
  } exp_t;

  exp_t sbq[$];

  always #5 clk = ~clk;

  // 4 clk per tick, 16 ticks per bit -> 64 clk per bit
  always @(posedge clk) begin
    tcnt   <= (tcnt == 3) ? 0 : tcnt + 1;
    s_tick <= (tcnt == 3);
  end

  uart_rx_cfg #(.DATA_BITS(8)) u0 (
    .clk(clk), .rst(rst), .rx(rx[0]), .s_tick(s_tick),
    .dout(d0), .rx_done(done[0]), .parity_err(pe[0]),
    .frame_err(fe[0]), .break_det(bk[0])
  );

  uart_rx_cfg #(.PARITY_EN(1), .PARITY_ODD(0)) u1 (
    .clk(clk), .rst(rst), .rx(rx[1]), .s_tick(s_tick),
    .dout(d1), .rx_done(done[1]), .parity_err(pe[1]),
    .frame_err(fe[1]), .break_det(bk[1])
  );

  uart_rx_cfg #(.STOP_BITS(2)) u2 (
    .clk(clk), .rst(rst), .rx(rx[2]), .s_tick(s_tick),
    .dout(d2), .rx_done(done[2]), .parity_err(pe[2]),
    .frame_err(fe[2]), .break_det(bk[2])
  );

  uart_rx_cfg #(.DATA_BITS(7), .LSB_FIRST(0)) u3 (
    .clk(clk), .rst(rst), .rx(rx[3]), .s_tick(s_tick),
    .dout(d3), .rx_done(done[3]), .parity_err(pe[3]),
    .frame_err(fe[3]), .break_det(bk[3])
  );

  function automatic logic [7:0] dsel(int k);
    case (k)
      0: return d0;
      1: return d1;
      2: return d2;
      3: return {1'b0, d3};
      default: return 8'h00;
    endcase
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clk(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(int k, logic v, int clks);
    rx[k] = v;
    wait_clk(clks);
  endtask

  // Queue the expected outcome, then drive start/data/parity/stop bits.
  task automatic send_frame(int k, int nd, bit lsb, logic [7:0] data,
                            bit pen, logic pbit, int nstop,
                            logic [1:0] stops, int last_clks);
    exp_t e;
    logic par;
    logic sbad;
    par = 1'b0;
    for (int i = 0; i < nd; i++) par ^= data[i];
    sbad = 1'b0;
    for (int j = 0; j < nstop; j++) sbad |= ~stops[j];
    e.k  = k;
    e.d  = data;
    e.pe = pen && ((par ^ pbit) != 1'b0);
    e.fe = sbad;
    e.bk = sbad && (data == 8'h00) && (!pen || !pbit);
    sbq.push_back(e);
    send_bit(k, 1'b0, BIT);
    for (int i = 0; i < nd; i++)
      send_bit(k, data[lsb ? i : nd - 1 - i], BIT);
    if (pen) send_bit(k, pbit, BIT);
    for (int j = 0; j < nstop; j++)
      send_bit(k, stops[j], (j == nstop - 1) ? last_clks : BIT);
    rx[k] = 1'b1;
    wait_clk(BIT);
  endtask

  task automatic chk_zero(string tag, int k);
    chk($sformatf("%s_dout%0d", tag, k), 32'(dsel(k)), 32'h0);
    chk($sformatf("%s_flags%0d", tag, k),
        32'({done[k], pe[k], fe[k], bk[k]}), 32'h0);
  endtask

  always @(negedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (done[k]) begin
        chk($sformatf("pulse_width%0d", k), 32'(done_q[k]), 32'h0);
        chk($sformatf("done_expected%0d", k),
            32'(sbq.size() != 0), 32'h1);
        if (sbq.size() != 0) begin
          exp_t e;
          e = sbq.pop_front();
          chk("dut_id", 32'(k), 32'(e.k));
          chk($sformatf("dout%0d", k), 32'(dsel(k)), 32'(e.d));
          chk($sformatf("parity_err%0d", k), 32'(pe[k]), 32'(e.pe));
          chk($sformatf("frame_err%0d", k), 32'(fe[k]), 32'(e.fe));
          chk($sformatf("break_det%0d", k), 32'(bk[k]), 32'(e.bk));
        end
      end
    end
    done_q <= done;
  end

  initial begin
    exp_t eb;
    rst = 1'b1;
    wait_clk(5);
    for (int k = 0; k < 4; k++) chk_zero("reset", k);
    rst = 1'b0;
    wait_clk(BIT);

    // 8N1 basic frame
    send_frame(0, 8, 1, 8'hA5, 0, 1'b0, 1, 2'b11, BIT);

    // start glitch of 4 ticks is rejected
    send_bit(0, 1'b0, 16);
    rx[0] = 1'b1;
    wait_clk(2 * BIT);
    chk("glitch_dout", 32'(d0), 32'hA5);
    chk("glitch_flags", 32'({pe[0], fe[0], bk[0]}), 32'h0);
    send_frame(0, 8, 1, 8'h3C, 0, 1'b0, 1, 2'b11, BIT);

    // even parity: wrong then correct parity bit
    send_frame(1, 8, 1, 8'h3C, 1, 1'b1, 1, 2'b11, BIT);
    send_frame(1, 8, 1, 8'h3C, 1, 1'b0, 1, 2'b11, BIT);

    // bad stop bit, 1 and 2 stop-bit configurations
    send_frame(0, 8, 1, 8'h55, 0, 1'b0, 1, 2'b10, 40);
    send_frame(2, 8, 1, 8'h55, 0, 1'b0, 2, 2'b01, 40);
    send_frame(2, 8, 1, 8'h55, 0, 1'b0, 2, 2'b11, BIT);

    // break: line low for 20 bit times, exactly one completion
    eb.k = 0; eb.d = 8'h00; eb.pe = 1'b0; eb.fe = 1'b1; eb.bk = 1'b1;
    sbq.push_back(eb);
    send_bit(0, 1'b0, 20 * BIT);
    rx[0] = 1'b1;
    wait_clk(2 * BIT);
    chk("break_held", 32'(bk[0]), 32'h1);
    send_frame(0, 8, 1, 8'h81, 0, 1'b0, 1, 2'b11, BIT);

    // leave a nonzero status, then reset during data bit 4
    send_frame(0, 8, 1, 8'h55, 0, 1'b0, 1, 2'b10, 40);
    send_bit(0, 1'b0, BIT);
    send_bit(0, 1'b1, BIT);
    send_bit(0, 1'b0, BIT);
    send_bit(0, 1'b0, BIT);
    send_bit(0, 1'b0, BIT);
    send_bit(0, 1'b0, BIT / 2);
    rst = 1'b1;
    rx[0] = 1'b1;
    #1;
    chk_zero("async_rst", 0);
    wait_clk(10);
    rst = 1'b0;
    wait_clk(2 * BIT);
    chk_zero("post_rst", 0);
    send_frame(0, 8, 1, 8'h81, 0, 1'b0, 1, 2'b11, BIT);

    // 7-bit MSB-first
    send_frame(3, 7, 0, 8'h5A, 0, 1'b0, 1, 2'b11, BIT);

    wait_clk(2 * BIT);
    chk("scoreboard_empty", 32'(sbq.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
